// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable bit rate and "all sent" interrupt.
// Optional even-parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_dev #(
    parameter int          FifoDepth   = 8,
    parameter logic [15:0] ClkDivReset = 16'd15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;

    // Control registers
    logic [15:0] clkdiv_reg;
    logic        ctrl_en_reg;
    logic        ctrl_irqen_reg;
    logic        ctrl_par_bit;
`ifdef UART_TX_PARITY_EN
    logic        ctrl_par_reg;
    logic        par_frame_reg;
`endif

    // Serialiser
    logic [2:0]  state_reg;
    logic [15:0] bit_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  data_reg;
    logic        tx_reg;
    logic        irq_reg;

    // Bus response
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [31:0] rdata_next;
    logic        err_next;

    logic [7:0]  reg_idx;
    logic        is_txdata, is_status, is_clkdiv, is_ctrl, addr_ok;
    logic        wr_acc;
    logic        full, empty, busy;
    logic        push, pop, tx_drop;
    logic        bit_end;
    logic [7:0]  pop_data;
    logic [7:0]  level;
    logic [31:0] status_word;
    logic        unused_bits;

    assign reg_idx   = addr_i[9:2];
    assign is_txdata = (reg_idx == 8'd0);
    assign is_status = (reg_idx == 8'd1);
    assign is_clkdiv = (reg_idx == 8'd2);
    assign is_ctrl   = (reg_idx == 8'd3);
    assign addr_ok   = (reg_idx < 8'd4);
    assign wr_acc    = req_i & we_i;

    assign full    = (count_reg == CntW'(FifoDepth));
    assign empty   = (count_reg == '0);
    assign busy    = (state_reg != ST_IDLE);
    assign bit_end = (bit_cnt_reg == 16'd0);

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign push    = wr_acc & is_txdata & be_i[0] & ~full;
    assign tx_drop = wr_acc & is_txdata & be_i[0] & full;
    assign pop     = ctrl_en_reg & ~empty &
                     ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & bit_end));
    assign pop_data = mem[rd_ptr_reg];

    assign level       = {{(8 - CntW){1'b0}}, count_reg};
    assign status_word = {16'd0, level, 5'd0, busy, empty, full};

`ifdef UART_TX_PARITY_EN
    assign ctrl_par_bit = ctrl_par_reg;
`else
    assign ctrl_par_bit = 1'b0;
`endif

    assign unused_bits = ^{addr_i[31:10], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CntW'(1);
                2'b01:   count_reg <= count_reg - CntW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkdiv_reg     <= ClkDivReset;
            ctrl_en_reg    <= 1'b0;
            ctrl_irqen_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            ctrl_par_reg   <= 1'b0;
`endif
        end else begin
            if (wr_acc && is_clkdiv) begin
                if (be_i[0]) clkdiv_reg[7:0]  <= wdata_i[7:0];
                if (be_i[1]) clkdiv_reg[15:8] <= wdata_i[15:8];
            end
            if (wr_acc && is_ctrl && be_i[0]) begin
                ctrl_en_reg    <= wdata_i[0];
                ctrl_irqen_reg <= wdata_i[1];
`ifdef UART_TX_PARITY_EN
                ctrl_par_reg   <= wdata_i[2];
`endif
            end
        end
    end

    always_comb begin
        rdata_next = 32'd0;
        if (req_i && !we_i) begin
            if (is_status) rdata_next = status_word;
            if (is_clkdiv) rdata_next = {16'd0, clkdiv_reg};
            if (is_ctrl)   rdata_next = {29'd0, ctrl_par_bit, ctrl_irqen_reg, ctrl_en_reg};
        end
        err_next = req_i & (~addr_ok | tx_drop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            rvalid_reg <= req_i;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
            irq_reg    <= ctrl_irqen_reg & empty & (state_reg == ST_IDLE);
        end
    end

    // The bit counter is reloaded from CLKDIV at every bit start, so divider changes land on bit boundaries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 16'd0;
            bit_idx_reg   <= 3'd0;
            data_reg      <= 8'd0;
            tx_reg        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_frame_reg <= 1'b0;
`endif
        end else begin
            if (state_reg != ST_IDLE && !bit_end) begin
                bit_cnt_reg <= bit_cnt_reg - 16'd1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg     <= ST_START;
                        tx_reg        <= 1'b0;
                        bit_cnt_reg   <= clkdiv_reg;
                        data_reg      <= pop_data;
`ifdef UART_TX_PARITY_EN
                        par_frame_reg <= ctrl_par_reg;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg   <= ST_DATA;
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= data_reg[0];
                        bit_cnt_reg <= clkdiv_reg;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt_reg <= clkdiv_reg;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (par_frame_reg) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= ^data_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                tx_reg    <= 1'b1;
                            end
`else
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= data_reg[bit_idx_reg + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg   <= ST_STOP;
                        tx_reg      <= 1'b1;
                        bit_cnt_reg <= clkdiv_reg;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state_reg     <= ST_START;
                            tx_reg        <= 1'b0;
                            bit_cnt_reg   <= clkdiv_reg;
                            data_reg      <= pop_data;
`ifdef UART_TX_PARITY_EN
                            par_frame_reg <= ctrl_par_reg;
`endif
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign rvalid_o = rvalid_reg;
    assign rdata_o  = rdata_reg;
    assign err_o    = err_reg;
    assign tx_o     = tx_reg;
    assign irq_o    = irq_reg;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: bus responses and serial frames are predicted from a
// register/FIFO model and checked by independent monitor processes.
module tb_uart_tx_dev;

    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        tx_o;
    logic        irq_o;

    uart_tx_dev #(.FifoDepth(DEPTH), .ClkDivReset(16'd15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .tx_o(tx_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } bus_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         div;
    } frame_t;

    bus_exp_t   bus_q[$];
    frame_t     frame_q[$];
    logic [7:0] pend_q[$];
    int         starts[$];

    // Reference model state
    int          model_level = 0;
    logic [15:0] model_clkdiv = 16'd15;
    logic [2:0]  model_ctrl = 3'd0;
    int          last_req_cyc = 0;

    // Bus monitor
    bus_exp_t mon_e;
    always @(negedge clk_i) begin
        if (!rst_i && rvalid_o) begin
            if (bus_q.size() == 0) begin
                check("unexpected rvalid", {31'd0, rvalid_o}, 32'd0);
            end else begin
                mon_e = bus_q.pop_front();
                $display("bus %s rdata=0x%08h err=%b", mon_e.name, rdata_o, err_o);
                check({mon_e.name, " rdata"}, rdata_o, mon_e.rdata);
                check({mon_e.name, " err"}, {31'd0, err_o}, {31'd0, mon_e.err});
            end
        end
    end

    // Serial monitor: decodes each frame and checks every bit for its full period
    int          frames_done = 0;
    int          fm_last_end = 0;
    int          fm_start;
    int          fm_nb;
    int          fm_k;
    logic [10:0] fm_bits;
    logic        fm_sample;
    logic        fm_bad;
    logic        fm_abort;
    frame_t      fm_f;

    initial begin : frame_mon
        forever begin
            @(negedge clk_i);
            if (!rst_i && tx_o === 1'b0) begin
                fm_start = cyc;
                if (frame_q.size() == 0) begin
                    check("unexpected frame start tx", {31'd0, tx_o}, 32'd1);
                    fm_k = 0;
                    while (tx_o !== 1'b1 && fm_k < 5000) begin
                        @(negedge clk_i);
                        fm_k++;
                    end
                end else begin
                    fm_f = frame_q.pop_front();
                    fm_bits = 11'h7FF;
                    fm_bits[0] = 1'b0;
                    fm_bits[8:1] = fm_f.data;
                    if (fm_f.par) begin
                        fm_bits[9] = ^fm_f.data;
                        fm_nb = 11;
                    end else begin
                        fm_nb = 10;
                    end
                    fm_abort = 1'b0;
                    for (int b = 0; b < fm_nb && !fm_abort; b++) begin
                        fm_bad = 1'b0;
                        fm_sample = fm_bits[b];
                        for (int c = 0; c <= fm_f.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk_i);
                            if (rst_i) begin
                                fm_abort = 1'b1;
                                break;
                            end
                            if (!fm_bad) begin
                                fm_sample = tx_o;
                                if (tx_o !== fm_bits[b]) fm_bad = 1'b1;
                            end
                        end
                        if (!fm_abort) begin
                            check($sformatf("frame %02h bit %0d", fm_f.data, b),
                                  {31'd0, fm_sample}, {31'd0, fm_bits[b]});
                        end
                    end
                    if (fm_abort) begin
                        $display("frame data=0x%02h start=%0d aborted by reset", fm_f.data, fm_start);
                    end else begin
                        frames_done++;
                        fm_last_end = cyc;
                        starts.push_back(fm_start);
                        $display("frame data=0x%02h start=%0d end=%0d bits=%0d", fm_f.data, fm_start, cyc, fm_nb);
                    end
                end
            end
        end
    end

    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                          input string name);
        bus_exp_t e;
        @(negedge clk_i);
        req_i = 1'b1;
        we_i = we;
        addr_i = addr;
        wdata_i = wdata;
        be_i = be;
        last_req_cyc = cyc;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.name = name;
        bus_q.push_back(e);
    endtask

    task automatic bus_idle();
        @(negedge clk_i);
        req_i = 1'b0;
        we_i = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] d);
        frame_t f;
        f.data = d;
        f.par = model_ctrl[2];
        f.div = int'(model_clkdiv);
        frame_q.push_back(f);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be,
                          input string name);
        logic err;
        err = 1'b0;
        case (off)
            32'h0: if (be[0]) begin
                if (model_ctrl[0]) push_frame(data[7:0]);
                else if (model_level >= DEPTH) err = 1'b1;
                else begin
                    model_level++;
                    pend_q.push_back(data[7:0]);
                end
            end
            32'h4: ;
            32'h8: begin
                if (be[0]) model_clkdiv[7:0] = data[7:0];
                if (be[1]) model_clkdiv[15:8] = data[15:8];
            end
            32'hC: if (be[0]) begin
                model_ctrl = data[2:0] & CTRL_MASK;
                if (model_ctrl[0]) begin
                    while (pend_q.size() > 0) push_frame(pend_q.pop_front());
                    model_level = 0;
                end
            end
            default: err = 1'b1;
        endcase
        bus_op(1'b1, off, data, be, 32'd0, err, name);
    endtask

    task automatic rd_reg(input logic [31:0] off, input string name);
        logic [31:0] exp;
        logic        err;
        err = 1'b0;
        case (off)
            32'h0: exp = 32'd0;
            32'h4: exp = {16'd0, 8'(model_level), 5'd0, 1'b0, (model_level == 0), (model_level == DEPTH)};
            32'h8: exp = {16'd0, model_clkdiv};
            32'hC: exp = {29'd0, model_ctrl};
            default: begin
                exp = 32'd0;
                err = 1'b1;
            end
        endcase
        bus_op(1'b0, off, 32'd0, 4'hF, exp, err, name);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        we_i = 1'b0;
        repeat (2) @(negedge clk_i);
        bus_q.delete();
        frame_q.delete();
        pend_q.delete();
        model_level = 0;
        model_clkdiv = 16'd15;
        model_ctrl = 3'd0;
        rst_i = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        check({name, " frames done"}, 32'(frames_done), 32'(target));
    endtask

    task automatic check_contiguous(input int count, input int div, input string name);
        int base;
        base = starts.size() - count;
        for (int i = 0; i < count - 1; i++) begin
            if (base + i + 1 < starts.size() && base >= 0)
                check({name, " frame spacing"}, 32'(starts[base + i + 1] - starts[base + i]), 32'(10 * (div + 1)));
        end
    endtask

    int   tgt;
    int   div;
    int   nbytes;
    int   wl;
    int   endc;
    int   prev;
    int   n;
    int   s;

    initial begin
        // Reset state
        do_reset();
        check("reset tx_o", {31'd0, tx_o}, 32'd1);
        check("reset irq_o", {31'd0, irq_o}, 32'd0);
        rd_reg(32'h4, "reset STATUS");
        rd_reg(32'h8, "reset CLKDIV");
        bus_idle();

        // Single byte 0xA5 with CLKDIV=3
        wr_reg(32'h8, 32'd3, 4'b0011, "CLKDIV=3");
        wr_reg(32'hC, 32'd1, 4'b0001, "CTRL=EN");
        wr_reg(32'h0, 32'hA5, 4'b0001, "TXDATA A5");
        wl = last_req_cyc;
        bus_idle();
        tgt = frames_done + 1;
        wait_frames(tgt, "single");
        if (starts.size() > 0) check("first frame latency", 32'(starts[starts.size() - 1] - wl), 32'd2);

        // Overflow with EN=0, then drain as contiguous frames
        wr_reg(32'hC, 32'd0, 4'b0001, "CTRL=0");
        for (int i = 0; i < DEPTH + 1; i++) wr_reg(32'h0, 32'($urandom_range(0, 255)), 4'b0001, $sformatf("fill %0d", i));
        rd_reg(32'h4, "full STATUS");
        wr_reg(32'hC, 32'd1, 4'b0001, "CTRL=EN drain");
        bus_idle();
        tgt = frames_done + DEPTH;
        wait_frames(tgt, "drain");
        check_contiguous(DEPTH, 3, "drain");

        // Back-to-back three bytes with interrupt
        div = $urandom_range(0, 4);
        wr_reg(32'h8, 32'(div), 4'b0011, "CLKDIV rand");
        wr_reg(32'hC, 32'd3, 4'b0001, "CTRL=EN|IRQEN");
        for (int i = 0; i < 3; i++) wr_reg(32'h0, 32'($urandom_range(0, 255)), 4'b0001, "b2b byte");
        bus_idle();
        tgt = frames_done + 3;
        wait_frames(tgt, "b2b");
        check_contiguous(3, div, "b2b");
        endc = fm_last_end;
        n = 0;
        while (cyc < endc + 1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("irq after last stop+1", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        check("irq after last stop+2", {31'd0, irq_o}, 32'd1);

        // Randomised batches
        wr_reg(32'hC, 32'd1, 4'b0001, "CTRL=EN");
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(0, 6);
            nbytes = $urandom_range(1, 4);
            wr_reg(32'h8, 32'(div), 4'b0011, "CLKDIV rand");
            for (int i = 0; i < nbytes; i++) wr_reg(32'h0, 32'($urandom_range(0, 255)), 4'b0001, "rand byte");
            bus_idle();
            tgt = frames_done + nbytes;
            wait_frames(tgt, "random");
            check_contiguous(nbytes, div, "random");
        end

        // Bus error and byte-enable behaviour
        wr_reg(32'hC, 32'd0, 4'b0001, "CTRL=0");
        rd_reg(32'h10, "read 0x10");
        wr_reg(32'h14, 32'h1234, 4'hF, "write 0x14");
        rd_reg(32'h0, "read TXDATA");
        wr_reg(32'h4, 32'hFFFF, 4'hF, "write STATUS");
        wr_reg(32'h8, 32'd3, 4'b0011, "CLKDIV=3");
        wr_reg(32'h8, 32'h00FF00FF, 4'b0001, "CLKDIV be0001");
        rd_reg(32'h8, "CLKDIV after be0001");
        wr_reg(32'hC, 32'd7, 4'b0001, "CTRL=7");
        rd_reg(32'hC, "CTRL readback");
        wr_reg(32'hC, 32'd0, 4'b0001, "CTRL=0");
        wr_reg(32'h8, 32'd3, 4'b0011, "CLKDIV=3");
        rd_reg(32'h4, "idle STATUS");
        bus_idle();

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has odd weight so the parity bit is 1
        wr_reg(32'hC, 32'd5, 4'b0001, "CTRL=EN|PAR");
        wr_reg(32'h0, 32'h07, 4'b0001, "TXDATA 07 parity");
        bus_idle();
        tgt = frames_done + 1;
        wait_frames(tgt, "parity");
        check("parity frame length", 32'(fm_last_end - starts[starts.size() - 1] + 1), 32'd44);
        wr_reg(32'hC, 32'd0, 4'b0001, "CTRL=0");
        bus_idle();
`endif

        // Reset during DATA bit 3 of a 0x00 frame
        wr_reg(32'hC, 32'd1, 4'b0001, "CTRL=EN");
        prev = starts.size();
        wr_reg(32'h0, 32'h00, 4'b0001, "TXDATA 00");
        bus_idle();
        n = 0;
        while (fm_start <= last_req_cyc && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        check("midframe start seen", {31'd0, tx_o}, 32'd0);
        s = fm_start;
        n = 0;
        while (cyc < s + 17 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        check("tx low in data bit 3", {31'd0, tx_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("tx_o high on async reset", {31'd0, tx_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        bus_q.delete();
        pend_q.delete();
        model_level = 0;
        model_clkdiv = 16'd15;
        model_ctrl = 3'd0;
        rst_i = 1'b0;
        rd_reg(32'h4, "STATUS after midframe reset");
        rd_reg(32'h8, "CLKDIV after midframe reset");
        bus_idle();
        repeat (20) @(negedge clk_i);
        check("starts unchanged by aborted frame", 32'(starts.size()), 32'(prev));
        check("frame queue drained", 32'(frame_q.size()), 32'd0);
        check("bus queue drained", 32'(bus_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
